// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the load/store sequencer.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR       = 3'd3,
    DONE     = 3'd4
  } mau_state_t;

  localparam logic [7:0]  LANE_MASK_BYTE = 8'hFF;
  localparam logic [15:0] LANE_MASK_HALF = 16'hFFFF;

  // Bit offset of the addressed lane inside a little-endian word.
  function automatic logic [4:0] lane_shift(input mem_size_t size, input logic [1:0] lane);
    logic [4:0] sh;
    case (size)
      MEM_BYTE: sh = {lane, 3'b000};
      MEM_HALF: sh = {lane[1], 4'b0000};
      default:  sh = 5'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: load extract/sign-extend and sub-word store merge.
module mem_lane_align #(
  parameter int unsigned BUS = 32
) (
  input  logic [BUS-1:0] rd_word,
  input  logic [BUS-1:0] wr_data,
  input  logic [1:0]     size,
  input  logic           sign_ext,
  input  logic [1:0]     lane,
  output logic [BUS-1:0] load_data_c,
  output logic [BUS-1:0] merge_data_c
);
  import mem_pkg::*;

  logic [4:0]     shamt;
  logic [7:0]     byte_v;
  logic [15:0]    half_v;
  logic [BUS-1:0] lane_mask;

  always_comb begin
    shamt       = lane_shift(mem_size_t'(size), lane);
    byte_v      = rd_word[{lane, 3'b000} +: 8];
    half_v      = rd_word[{lane[1], 4'b0000} +: 16];
    load_data_c = rd_word;
    lane_mask   = {BUS{1'b1}};
    case (mem_size_t'(size))
      MEM_BYTE: begin
        lane_mask   = BUS'(LANE_MASK_BYTE) << shamt;
        load_data_c = {{(BUS-8){sign_ext & byte_v[7]}}, byte_v};
      end
      MEM_HALF: begin
        lane_mask   = BUS'(LANE_MASK_HALF) << shamt;
        load_data_c = {{(BUS-16){sign_ext & half_v[15]}}, half_v};
      end
      default: ;
    endcase
    // Untouched lanes keep the read-back bytes.
    merge_data_c = (rd_word & ~lane_mask) | ((wr_data << shamt) & lane_mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and a word-indexed data memory.
module mem_access_unit #(
  parameter int unsigned BUS       = 32,
  parameter int unsigned MEM_WORDS = 4096
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_write,
  input  logic [1:0]     req_size,
  input  logic           req_signed,
  input  logic [BUS-1:0] req_addr,
  input  logic [BUS-1:0] req_wdata,
  output logic           resp_valid,
  output logic [BUS-1:0] resp_rdata,
  output logic           resp_fault,
  output logic [BUS-1:0] mem_readdir,
  output logic [BUS-1:0] mem_writedir,
  output logic [BUS-1:0] mem_datain,
  output logic           mem_MRE,
  output logic           mem_MWE,
  input  logic [BUS-1:0] mem_dataout
);
  import mem_pkg::*;

  mau_state_t     state_q, state_d;
  logic           write_q, signed_q;
  logic [1:0]     size_q, lane_q;
  logic           accept_c, fault_c, word_store_c;
  logic [BUS-1:0] index_c, load_data_c, merge_data_c;

  assign accept_c     = req_valid & (state_q == IDLE);
  assign index_c      = BUS'(req_addr[BUS-1:2]);
  assign word_store_c = req_write & (mem_size_t'(req_size) == MEM_WORD);

  // Fault decode on the live request; only consumed on the accept edge.
  always_comb begin
    fault_c = (index_c >= BUS'(MEM_WORDS));
    case (mem_size_t'(req_size))
      MEM_HALF: if (req_addr[0]) fault_c = 1'b1;
      MEM_WORD: if (req_addr[1:0] != 2'b00) fault_c = 1'b1;
      MEM_RSVD: fault_c = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (fault_c)           state_d = DONE;
          else if (word_store_c) state_d = WR;
          else                   state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT:  state_d = write_q ? WR : DONE;
      WR:       state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Control outputs are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      mem_MRE    <= 1'b0;
      mem_MWE    <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_ready  <= (state_d == IDLE);
      resp_valid <= (state_d == DONE);
      mem_MRE    <= (state_d == RD_ISSUE);
      mem_MWE    <= (state_d == WR);
    end
  end

  // Request capture and data path; mem_datain holds store data until the merge replaces it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q      <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
      mem_readdir  <= '0;
      mem_writedir <= '0;
      mem_datain   <= '0;
      resp_rdata   <= '0;
      resp_fault   <= 1'b0;
    end else if (accept_c) begin
      write_q      <= req_write;
      signed_q     <= req_signed;
      size_q       <= req_size;
      lane_q       <= req_addr[1:0];
      mem_readdir  <= index_c;
      mem_writedir <= index_c;
      mem_datain   <= req_wdata;
      resp_rdata   <= '0;
      resp_fault   <= fault_c;
    end else if (state_q == RD_WAIT) begin
      if (write_q) mem_datain <= merge_data_c;
      else         resp_rdata <= load_data_c;
    end else if (state_q == DONE) begin
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end
  end

  mem_lane_align #(.BUS(BUS)) u_lane_align (
    .rd_word      (mem_dataout),
    .wr_data      (mem_datain),
    .size         (size_q),
    .sign_ext     (signed_q),
    .lane         (lane_q),
    .load_data_c  (load_data_c),
    .merge_data_c (merge_data_c)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a posedge-read / negedge-write memory model.
module tb_mem_access_unit;
  localparam int unsigned BUS       = 32;
  localparam int unsigned MEM_WORDS = 4096;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid, req_ready, req_write, req_signed;
  logic [1:0]     req_size;
  logic [BUS-1:0] req_addr, req_wdata;
  logic           resp_valid, resp_fault;
  logic [BUS-1:0] resp_rdata;
  logic [BUS-1:0] mem_readdir, mem_writedir, mem_datain, mem_dataout;
  logic           mem_MRE, mem_MWE;

  mem_access_unit #(.BUS(BUS), .MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_readdir(mem_readdir), .mem_writedir(mem_writedir), .mem_datain(mem_datain),
    .mem_MRE(mem_MRE), .mem_MWE(mem_MWE), .mem_dataout(mem_dataout)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [MEM_WORDS];
  initial mem_dataout = '0;
  always @(posedge clk)
    if (mem_MRE && mem_readdir < MEM_WORDS) mem_dataout <= mem[mem_readdir[11:0]];
  always @(negedge clk)
    if (mem_MWE && mem_writedir < MEM_WORDS) mem[mem_writedir[11:0]] = mem_datain;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, n_acc = 0, n_resp = 0, mem_act = 0, busy_viol = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Accept tracker: records the edge number of every handshake.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      acc_q.delete();
      n_acc = n_resp;
    end else if (req_valid && req_ready) begin
      acc_q.push_back(cyc + 1);
      n_acc++;
    end
  end

  // Response monitor: latency counts edges from accept to the edge where resp is consumed.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      int   a;
      if (mem_MRE || mem_MWE) mem_act++;
      if (req_ready && (n_acc != n_resp)) busy_viol++;
      if (resp_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: got rdata 0x%08h fault %0b with nothing expected", resp_rdata, resp_fault);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk($sformatf("resp%0d_rdata", n_resp), resp_rdata, e.rdata);
          chk($sformatf("resp%0d_fault", n_resp), 32'(resp_fault), 32'(e.fault));
          chk($sformatf("resp%0d_latency", n_resp), 32'(cyc + 1 - a), 32'(e.lat));
          n_resp++;
        end
      end
    end
  end

  task automatic send(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] er, input logic ef, input int el,
                      input bit hold);
    bit ok = 1'b0;
    exp_q.push_back('{rdata: er, fault: ef, lat: el});
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    for (int n = 0; n < 200; n++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready 0 for addr 0x%08h expected 1", a);
      void'(exp_q.pop_back());
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (!hold) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = 32'h5A5A_5A5A;
      req_size  = 2'b11;
      req_write = ~w;
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got %0d pending responses expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int act0;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mre", 32'(mem_MRE), 32'd0);
    chk("rst_mwe", 32'(mem_MWE), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;

    // Word store then load back.
    send(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b0);
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b0);
    wait_idle();
    chk("str_mem4", mem[4], 32'hDEADBEEF);

    // Sub-word stores: only the addressed lane changes.
    mem[3] = 32'h33333333; mem[4] = 32'h11223344; mem[5] = 32'h55667788;
    send(1'b1, 2'b00, 1'b0, 32'h11, 32'h123456AA, 32'h0, 1'b0, 4, 1'b0);
    send(1'b1, 2'b01, 1'b0, 32'h16, 32'hCAFEBEEF, 32'h0, 1'b0, 4, 1'b0);
    wait_idle();
    chk("strb_mem4", mem[4], 32'h1122AA44);
    chk("strh_mem5", mem[5], 32'hBEEF7788);
    chk("strb_mem3_kept", mem[3], 32'h33333333);

    // Sub-word loads with zero and sign extension.
    mem[4] = 32'h80FF7F01;
    send(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 32'hFFFFFFFF, 1'b0, 3, 1'b0);
    send(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'h000000FF, 1'b0, 3, 1'b0);
    send(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF80FF, 1'b0, 3, 1'b0);
    send(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h00007F01, 1'b0, 3, 1'b0);
    send(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1'b0);
    send(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h00007F01, 1'b0, 3, 1'b0);
    send(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h00000080, 1'b0, 3, 1'b0);
    wait_idle();

    // Faults never touch memory.
    act0 = mem_act;
    send(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1, 1'b0);
    send(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 32'h0, 1'b1, 1, 1'b0);
    send(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 1, 1'b0);
    send(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1'b0);
    send(1'b1, 2'b10, 1'b0, 32'h4000, 32'h11111111, 32'h0, 1'b1, 1, 1'b0);
    send(1'b1, 2'b01, 1'b0, 32'h13, 32'h22222222, 32'h0, 1'b1, 1, 1'b0);
    wait_idle();
    chk("fault_no_mem_access", 32'(mem_act), 32'(act0));
    chk("fault_mem4_kept", mem[4], 32'h80FF7F01);

    // Three requests with req_valid held high: strictly in order.
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80FF7F01, 1'b0, 3, 1'b1);
    send(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'hBEEF7788, 1'b0, 3, 1'b1);
    send(1'b0, 2'b00, 1'b1, 32'h17, 32'h0, 32'hFFFFFFBE, 1'b0, 3, 1'b0);
    wait_idle();

    // Reset inside the WR cycle, before its negedge, suppresses the write.
    mem[8] = 32'h0BADF00D;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    chk("wr_cycle_mwe", 32'(mem_MWE), 32'd1);
    #1;
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rst_async_mwe", 32'(mem_MWE), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wr_mem8_kept", mem[8], 32'h0BADF00D);
    chk("rst_wr_ready", 32'(req_ready), 32'd1);
    chk("rst_wr_resp_valid", 32'(resp_valid), 32'd0);
    send(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0BADF00D, 1'b0, 3, 1'b0);
    wait_idle();

    chk("ready_while_busy", 32'(busy_viol), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
